alu_multiciclo: RTL and testbench
=================================

// Module: alu_multiciclo
// PURPOSE
//  Parametrised, registered ALU for the datapath: generalises the combinational 32-bit ALU to WIDTH bits.
//  Adds valid/ready handshakes on input and output, and a multi-cycle shift-add multiplier.
//  Sits between the decode stage (operands + opcode) and register writeback; flags feed the branch unit.
// PARAMETERS
//  WIDTH   32   operand/result width; power of two, >= 4. SHW = $clog2(WIDTH) is derived (localparam).
// PORTS
//  clk         in   1      single clock, all logic rising-edge
//  reset       in   1      synchronous, active-high
//  in_valid    in   1      operands/opcode valid
//  in_ready    out  1      block can accept an operation
//  opcode      in   5      operation select (encoding below)
//  operando_a  in   WIDTH  operand A
//  operando_b  in   WIDTH  operand B
//  out_valid   out  1      resultado/flags valid
//  out_ready   in   1      consumer accepts result
//  resultado   out  WIDTH  result
//  C,S,O,Z     out  1 each carry/borrow, sign (resultado[WIDTH-1]), signed overflow, zero
// BEHAVIOUR
//  Reset: state=IDLE; out_valid=0; resultado=0; C=S=O=Z=0; multiplier regs cleared; in_ready=0 while reset high.
//  FSM: IDLE -> (accept, op!=MUL) -> DONE; IDLE -> (accept, MUL) -> MUL; MUL -> (iterations done) -> DONE;
//       DONE -> (out_valid & out_ready) -> IDLE. No accept in the same cycle as output handshake.
//  in_ready = (state==IDLE) & !reset. Accept = in_valid & in_ready; operands/opcode captured; later input changes ignored.
//  Opcodes: 00 NOP, 01 ADD, 02 SUB, 03 MUL, 04 AND, 05 OR, 06 XOR, 07 SHL, 08 SHR (logical); 09-1F act as NOP.
//  NOP/undefined: resultado=0, Z=1, C=S=O=0.
//  ADD: {C,R}=A+B; O=(A[msb]==B[msb]) & (R[msb]!=A[msb]).
//  SUB: R=A-B; C=1 iff A<B unsigned (borrow); O=(A[msb]!=B[msb]) & (R[msb]!=A[msb]).
//  MUL: unsigned; 2*WIDTH product; R=low half; C=O=(high half != 0).
//  AND/OR/XOR: C=O=0.
//  SHL/SHR: shift amount = B[SHW-1:0]; C = last bit shifted out (0 if amount 0); O=0.
//  All ops: S=R[WIDTH-1], Z=(R==0); flags registered with resultado, same cycle.
//  Latency, single-cycle ops: accept in cycle N -> out_valid=1 in cycle N+1.
//  Latency, MUL: one shift-add iteration per cycle over bits of B, LSB first; WIDTH iterations.
//       Accept at N -> out_valid at N+WIDTH+1.
//  Backpressure: while out_valid & !out_ready, resultado/flags/out_valid held stable and in_ready=0.
//  out_valid deasserts the cycle after the handshake; resultado/flags retain their last value.
//  Reset mid-operation (MUL or DONE): operation discarded, no output produced; all outputs return to reset values.
// CONFIGURATION
//  ALU_EARLY_TERM_EN defined: MUL stops once the remaining bits of B are all zero.
//    iterations = max(1, index of highest set bit of B + 1); B=0 -> 1 iteration, R=0.
//  ALU_EARLY_TERM_EN undefined: always WIDTH iterations. Results and flags are identical in both builds;
//    only latency differs.
// TESTING (WIDTH=32)
//  1. ADD A=8000_0002 B=8000_0001 -> R=0000_0003, C=1, O=1, S=0, Z=0; out_valid exactly 1 cycle after accept.
//  2. MUL A=0261_1500 B=0000_000C -> R=1C8C_FC00, C=O=0, Z=0.
//     out_valid at accept+33; with ALU_EARLY_TERM_EN at accept+5.
//  3. MUL A=0000_0001 B=8000_0002 -> R=8000_0002, S=1.
//     MUL A=0001_0000 B=0001_0000 -> R=0, C=O=1, Z=1.
//  4. SUB A=0000_0001 B=0000_0002 -> R=FFFF_FFFF, C=1, S=1, O=0.
//     SHL A=8000_0001 B=1 -> R=0000_0002, C=1.
//     Opcode 1F -> R=0, Z=1.
//  5. Hold out_ready=0 for 5 cycles after a result -> R/flags/out_valid stable, in_ready=0.
//     in_valid pulses in that window are not accepted.
//  6. Assert reset at MUL iteration 10 -> next cycle out_valid=0, R=0, flags=0.
//     After release in_ready=1; a following ADD 2+3 returns R=5 with normal latency.

Source files
------------

// File: rtl/alu_multiciclo.sv
// Registered WIDTH-bit ALU with valid/ready handshakes on both sides and a
// multi-cycle shift-add unsigned multiplier.
// Optional build macro: ALU_EARLY_TERM_EN stops the multiply once the
// remaining multiplier bits are all zero. Results and flags do not change,
// only the latency does.
//
// state | meaning
// IDLE  | waiting for an operation, in_ready high
// MUL   | shift-add iterations running, one bit of B per cycle
// DONE  | resultado/flags valid, waiting for out_ready
module alu_multiciclo #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       opcode,
    input  logic [WIDTH-1:0] operando_a,
    input  logic [WIDTH-1:0] operando_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] resultado,
    output logic             C,
    output logic             S,
    output logic             O,
    output logic             Z
);
    localparam int SHW = $clog2(WIDTH);
    localparam int MSB = WIDTH - 1;
    localparam logic [SHW-1:0] CNT_INIT = SHW'(WIDTH - 1);
    localparam logic [SHW-1:0] CNT_ONE  = SHW'(1);

    localparam logic [4:0] OP_ADD = 5'h01;
    localparam logic [4:0] OP_SUB = 5'h02;
    localparam logic [4:0] OP_MUL = 5'h03;
    localparam logic [4:0] OP_AND = 5'h04;
    localparam logic [4:0] OP_OR  = 5'h05;
    localparam logic [4:0] OP_XOR = 5'h06;
    localparam logic [4:0] OP_SHL = 5'h07;
    localparam logic [4:0] OP_SHR = 5'h08;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DONE
    } state_t;

    state_t             state_q, state_d;
    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   resultado_q, resultado_d;
    logic               c_q, c_d, s_q, s_d, o_q, o_d, z_q, z_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [SHW-1:0]     cnt_q, cnt_d;

    logic [WIDTH-1:0]   alu_r;
    logic               alu_c, alu_o;
    logic [WIDTH:0]     sum_ext, shl_ext, shr_ext;
    logic [SHW-1:0]     shamt;
    logic [2*WIDTH-1:0] prod_next;
    logic               mul_last;
    logic               accept;

    assign in_ready  = (state_q == ST_IDLE) && !reset;
    assign accept    = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign resultado = resultado_q;
    assign C = c_q;
    assign S = s_q;
    assign O = o_q;
    assign Z = z_q;

    // Single-cycle operations, evaluated straight from the input operands.
    // The shifts run one bit wider so the last bit shifted out lands in the
    // extra position and becomes the carry.
    always_comb begin
        alu_r   = '0;
        alu_c   = 1'b0;
        alu_o   = 1'b0;
        sum_ext = '0;
        shl_ext = '0;
        shr_ext = '0;
        shamt   = operando_b[SHW-1:0];
        case (opcode)
            OP_ADD: begin
                sum_ext = {1'b0, operando_a} + {1'b0, operando_b};
                alu_r   = sum_ext[WIDTH-1:0];
                alu_c   = sum_ext[WIDTH];
                alu_o   = (operando_a[MSB] == operando_b[MSB]) && (alu_r[MSB] != operando_a[MSB]);
            end
            OP_SUB: begin
                sum_ext = {1'b0, operando_a} - {1'b0, operando_b};
                alu_r   = sum_ext[WIDTH-1:0];
                alu_c   = sum_ext[WIDTH];
                alu_o   = (operando_a[MSB] != operando_b[MSB]) && (alu_r[MSB] != operando_a[MSB]);
            end
            OP_AND: alu_r = operando_a & operando_b;
            OP_OR:  alu_r = operando_a | operando_b;
            OP_XOR: alu_r = operando_a ^ operando_b;
            OP_SHL: begin
                shl_ext = {1'b0, operando_a} << shamt;
                alu_r   = shl_ext[WIDTH-1:0];
                alu_c   = shl_ext[WIDTH];
            end
            OP_SHR: begin
                shr_ext = {operando_a, 1'b0} >> shamt;
                alu_r   = shr_ext[WIDTH:1];
                alu_c   = shr_ext[0];
            end
            default: begin
                alu_r = '0;
            end
        endcase
    end

    // One shift-add step and the decision whether it is the final one.
    always_comb begin
        prod_next = mplier_q[0] ? (prod_q + mcand_q) : prod_q;
`ifdef ALU_EARLY_TERM_EN
        mul_last  = (cnt_q == '0) || (mplier_q[WIDTH-1:1] == '0);
`else
        mul_last  = (cnt_q == '0);
`endif
    end

    // Next-state, datapath loads and registered outputs.
    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        resultado_d = resultado_q;
        c_d         = c_q;
        s_d         = s_q;
        o_d         = o_q;
        z_d         = z_q;
        prod_d      = prod_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        cnt_d       = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (opcode == OP_MUL) begin
                        prod_d   = '0;
                        mcand_d  = {{WIDTH{1'b0}}, operando_a};
                        mplier_d = operando_b;
                        cnt_d    = CNT_INIT;
                        state_d  = ST_MUL;
                    end else begin
                        resultado_d = alu_r;
                        c_d         = alu_c;
                        o_d         = alu_o;
                        s_d         = alu_r[MSB];
                        z_d         = (alu_r == '0);
                        out_valid_d = 1'b1;
                        state_d     = ST_DONE;
                    end
                end
            end
            ST_MUL: begin
                prod_d   = prod_next;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q - CNT_ONE;
                if (mul_last) begin
                    resultado_d = prod_next[WIDTH-1:0];
                    c_d         = (prod_next[2*WIDTH-1:WIDTH] != '0);
                    o_d         = (prod_next[2*WIDTH-1:WIDTH] != '0);
                    s_d         = prod_next[MSB];
                    z_d         = (prod_next[WIDTH-1:0] == '0);
                    out_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers; a reset discards any operation in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            resultado_q <= '0;
            c_q         <= 1'b0;
            s_q         <= 1'b0;
            o_q         <= 1'b0;
            z_q         <= 1'b0;
            prod_q      <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            resultado_q <= resultado_d;
            c_q         <= c_d;
            s_q         <= s_d;
            o_q         <= o_d;
            z_q         <= z_d;
            prod_q      <= prod_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            cnt_q       <= cnt_d;
        end
    end

endmodule

// File: tb/tb_alu_multiciclo.sv
// Directed bench for alu_multiciclo at WIDTH=32. Expected MUL latencies
// follow the ALU_EARLY_TERM_EN build macro when it is defined.
module tb_alu_multiciclo;
    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  opcode;
    logic [31:0] operando_a;
    logic [31:0] operando_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] resultado;
    logic        C, S, O, Z;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic [3:0]  f;    // {C,S,O,Z}
        int          lat_full;
        int          lat_early;
    } vec_t;

    alu_multiciclo #(.WIDTH(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .opcode     (opcode),
        .operando_a (operando_a),
        .operando_b (operando_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .resultado  (resultado),
        .C          (C),
        .S          (S),
        .O          (O),
        .Z          (Z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Presents one operation, scrambles the inputs right after the accepting
    // edge, and counts negedges until out_valid (1 = next cycle).
    task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output logic rdy_at_accept);
        @(negedge clk);
        opcode     = op;
        operando_a = a;
        operando_b = b;
        in_valid   = 1'b1;
        out_ready  = 1'b1;
        rdy_at_accept = in_ready;
        @(posedge clk);
        #1;
        in_valid   = 1'b0;
        opcode     = 5'h06;
        operando_a = 32'hDEAD_BEEF;
        operando_b = 32'h1234_5678;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 100);
    endtask

    task automatic test_reset;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        opcode = '0; operando_a = '0; operando_b = '0;
        repeat (3) @(negedge clk);
        total++;
        if ({out_valid, resultado, C, S, O, Z} !== 37'd0) begin
            bad++;
            $display("FAIL reset_outputs: got ov=%b r=%h f=%b%b%b%b want all zero", out_valid, resultado, C, S, O, Z);
        end
        total++;
        if (in_ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_in_ready: got %b want 0", in_ready);
        end
        reset = 1'b0;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL post_reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_single_cycle_ops;
        vec_t v [16];
        int   lat;
        logic rdy;
        v[0]  = '{5'h01, 32'h8000_0002, 32'h8000_0001, 32'h0000_0003, 4'b1010, 1, 1};
        v[1]  = '{5'h01, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 4'b1001, 1, 1};
        v[2]  = '{5'h01, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 4'b0110, 1, 1};
        v[3]  = '{5'h02, 32'h0000_0001, 32'h0000_0002, 32'hFFFF_FFFF, 4'b1100, 1, 1};
        v[4]  = '{5'h02, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 4'b0010, 1, 1};
        v[5]  = '{5'h02, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 4'b0001, 1, 1};
        v[6]  = '{5'h04, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 4'b0000, 1, 1};
        v[7]  = '{5'h05, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFFF0_FFF0, 4'b0100, 1, 1};
        v[8]  = '{5'h06, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFF00_FF00, 4'b0100, 1, 1};
        v[9]  = '{5'h07, 32'h8000_0001, 32'h0000_0001, 32'h0000_0002, 4'b1000, 1, 1};
        v[10] = '{5'h07, 32'h8000_0000, 32'h0000_0020, 32'h8000_0000, 4'b0100, 1, 1};
        v[11] = '{5'h07, 32'h0000_0003, 32'h0000_003F, 32'h8000_0000, 4'b1100, 1, 1};
        v[12] = '{5'h08, 32'h0000_0003, 32'h0000_0001, 32'h0000_0001, 4'b1000, 1, 1};
        v[13] = '{5'h08, 32'h8000_0000, 32'h0000_001F, 32'h0000_0001, 4'b0000, 1, 1};
        v[14] = '{5'h1F, 32'h0000_0005, 32'h0000_0007, 32'h0000_0000, 4'b0001, 1, 1};
        v[15] = '{5'h00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 4'b0001, 1, 1};
        for (int i = 0; i < 16; i++) begin
            run_op(v[i].op, v[i].a, v[i].b, lat, rdy);
            total++;
            if (rdy !== 1'b1) begin
                bad++;
                $display("FAIL single_in_ready[%0d]: got %b want 1", i, rdy);
            end
            total++;
            if (lat != v[i].lat_full) begin
                bad++;
                $display("FAIL single_latency[%0d] op=%h: got %0d want %0d", i, v[i].op, lat, v[i].lat_full);
            end
            total++;
            if (resultado !== v[i].r) begin
                bad++;
                $display("FAIL single_result[%0d] op=%h: got %h want %h", i, v[i].op, resultado, v[i].r);
            end
            total++;
            if ({C, S, O, Z} !== v[i].f) begin
                bad++;
                $display("FAIL single_flags[%0d] op=%h: got CSOZ=%b%b%b%b want %b", i, v[i].op, C, S, O, Z, v[i].f);
            end
        end
    endtask

    task automatic test_mul;
        vec_t v [5];
        int   lat;
        int   want_lat;
        logic rdy;
        v[0] = '{5'h03, 32'h0261_1500, 32'h0000_000C, 32'h1C8C_FC00, 4'b0000, 33, 5};
        v[1] = '{5'h03, 32'h0000_0001, 32'h8000_0002, 32'h8000_0002, 4'b0100, 33, 33};
        v[2] = '{5'h03, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 4'b1011, 33, 18};
        v[3] = '{5'h03, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000, 4'b0001, 33, 2};
        v[4] = '{5'h03, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 4'b1010, 33, 33};
        for (int i = 0; i < 5; i++) begin
`ifdef ALU_EARLY_TERM_EN
            want_lat = v[i].lat_early;
`else
            want_lat = v[i].lat_full;
`endif
            run_op(v[i].op, v[i].a, v[i].b, lat, rdy);
            total++;
            if (lat != want_lat) begin
                bad++;
                $display("FAIL mul_latency[%0d]: got %0d want %0d", i, lat, want_lat);
            end
            total++;
            if (resultado !== v[i].r) begin
                bad++;
                $display("FAIL mul_result[%0d]: got %h want %h", i, resultado, v[i].r);
            end
            total++;
            if ({C, S, O, Z} !== v[i].f) begin
                bad++;
                $display("FAIL mul_flags[%0d]: got CSOZ=%b%b%b%b want %b", i, C, S, O, Z, v[i].f);
            end
        end
    endtask

    task automatic test_backpressure;
        @(negedge clk);
        opcode = 5'h01; operando_a = 32'd5; operando_b = 32'd6;
        in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++;
            if ({out_valid, in_ready, resultado, C, S, O, Z} !== {1'b1, 1'b0, 32'd11, 4'b0000}) begin
                bad++;
                $display("FAIL hold[%0d]: got ov=%b ir=%b r=%h CSOZ=%b%b%b%b want ov=1 ir=0 r=0000000b CSOZ=0000",
                         i, out_valid, in_ready, resultado, C, S, O, Z);
            end
            in_valid   = (i % 2 == 0);
            opcode     = 5'h02;
            operando_a = 32'd100;
            operando_b = 32'd1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        total++;
        if ({out_valid, in_ready, resultado} !== {1'b0, 1'b1, 32'd11}) begin
            bad++;
            $display("FAIL after_handshake: got ov=%b ir=%b r=%h want ov=0 ir=1 r=0000000b", out_valid, in_ready, resultado);
        end
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL no_stale_accept: got ov=%b want 0", out_valid);
        end
    endtask

    task automatic test_reset_mid_mul;
        int   lat;
        int   seen_valid;
        logic rdy;
        @(negedge clk);
        opcode = 5'h03; operando_a = 32'd3; operando_b = 32'd5;
        in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        total++;
        if ({out_valid, in_ready, resultado, C, S, O, Z} !== 38'd0) begin
            bad++;
            $display("FAIL mid_reset_outputs: got ov=%b ir=%b r=%h CSOZ=%b%b%b%b want all zero",
                     out_valid, in_ready, resultado, C, S, O, Z);
        end
        reset = 1'b0;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL mid_reset_release_in_ready: got %b want 1", in_ready);
        end
        seen_valid = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen_valid++;
        end
        total++;
        if (seen_valid != 0) begin
            bad++;
            $display("FAIL discarded_mul: got %0d cycles of out_valid want 0", seen_valid);
        end
        run_op(5'h01, 32'd2, 32'd3, lat, rdy);
        total++;
        if ({lat == 1, resultado, C, S, O, Z} !== {1'b1, 32'd5, 4'b0000}) begin
            bad++;
            $display("FAIL add_after_reset: got lat=%0d r=%h CSOZ=%b%b%b%b want lat=1 r=00000005 CSOZ=0000",
                     lat, resultado, C, S, O, Z);
        end
    endtask

    initial begin
        test_reset();
        test_single_cycle_ops();
        test_mul();
        test_backpressure();
        test_reset_mid_mul();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
